// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit time-multiplexed 7-segment driver with per-frame snapshot.
// Inter-digit dead-time blanking is compiled in with `define SEG7_SCAN_DEADTIME_EN.
module seg7_scan_driver #(
    parameter int unsigned PRESCALE      = 1000,
    parameter int unsigned DEAD_CYCLES   = 8,
    parameter logic [7:0]  BLANK_PATTERN = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] l_in0,
    input  logic [7:0] l_in1,
    input  logic [7:0] l_in2,
    input  logic [7:0] l_in3,
    input  logic [7:0] r_in0,
    input  logic [7:0] r_in1,
    input  logic [7:0] r_in2,
    input  logic [7:0] r_in3,
    output logic [7:0] seg_out,
    output logic [7:0] digit_sel,
    output logic [2:0] scan_index,
    output logic       frame_tick
);

    if (PRESCALE < 2 || PRESCALE > 65535 || DEAD_CYCLES < 1 || DEAD_CYCLES >= PRESCALE) begin : g_param_check
        $error("seg7_scan_driver: PRESCALE or DEAD_CYCLES out of range");
    end

    localparam logic [15:0] CNT_LAST = 16'(PRESCALE - 1);

    logic [15:0]     cnt_q, cnt_d, cnt_cur;
    logic [2:0]      idx_q, idx_d;
    logic [7:0][7:0] snap_q, snap_d, in_pat;
    logic            load_pending_q, load_pending_d;
    logic            enable_prev_q, enable_prev_d;
    logic [7:0]      seg_q, seg_d;
    logic [7:0]      sel_q, sel_d;
    logic [2:0]      scan_q, scan_d;
    logic            tick_q, tick_d;
    logic            slot_last, frame_wrap, active;

    assign in_pat = {r_in3, r_in2, r_in1, r_in0, l_in3, l_in2, l_in1, l_in0};

    always_comb begin
        // A re-enabled scan starts its slot from the beginning so the digit gets a full slot.
        cnt_cur    = (enable && !enable_prev_q) ? 16'd0 : cnt_q;
        slot_last  = (cnt_cur == CNT_LAST);
        frame_wrap = enable && slot_last && (idx_q == 3'd7);
`ifdef SEG7_SCAN_DEADTIME_EN
        active     = enable && (cnt_cur >= 16'(DEAD_CYCLES));
`else
        active     = enable;
`endif

        cnt_d          = cnt_q;
        idx_d          = idx_q;
        snap_d         = snap_q;
        load_pending_d = load_pending_q;
        enable_prev_d  = enable;

        if (enable) begin
            cnt_d = slot_last ? 16'd0 : cnt_cur + 16'd1;
            if (slot_last) begin
                idx_d = idx_q + 3'd1;
            end
            if (load_pending_q || frame_wrap) begin
                snap_d         = in_pat;
                load_pending_d = 1'b0;
            end
        end

        seg_d  = active ? snap_q[idx_q] : BLANK_PATTERN;
        sel_d  = active ? ~(8'd1 << idx_q) : 8'hFF;
        scan_d = idx_q;
        tick_d = frame_wrap;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q          <= 16'd0;
            idx_q          <= 3'd0;
            snap_q         <= {8{BLANK_PATTERN}};
            load_pending_q <= 1'b1;
            enable_prev_q  <= 1'b0;
            seg_q          <= BLANK_PATTERN;
            sel_q          <= 8'hFF;
            scan_q         <= 3'd0;
            tick_q         <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            snap_q         <= snap_d;
            load_pending_q <= load_pending_d;
            enable_prev_q  <= enable_prev_d;
            seg_q          <= seg_d;
            sel_q          <= sel_d;
            scan_q         <= scan_d;
            tick_q         <= tick_d;
        end
    end

    assign seg_out    = seg_q;
    assign digit_sel  = sel_q;
    assign scan_index = scan_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver (PRESCALE=4, DEAD_CYCLES=1).
module tb_seg7_scan_driver;

`ifdef SEG7_SCAN_DEADTIME_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset, enable;
    logic [7:0] l_in0, l_in1, l_in2, l_in3, r_in0, r_in1, r_in2, r_in3;
    logic [7:0] seg_out, digit_sel;
    logic [2:0] scan_index;
    logic       frame_tick;

    always #5 clock = ~clock;

    seg7_scan_driver #(.PRESCALE(4), .DEAD_CYCLES(1), .BLANK_PATTERN(8'hFF)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .l_in0(l_in0), .l_in1(l_in1), .l_in2(l_in2), .l_in3(l_in3),
        .r_in0(r_in0), .r_in1(r_in1), .r_in2(r_in2), .r_in3(r_in3),
        .seg_out(seg_out), .digit_sel(digit_sel), .scan_index(scan_index), .frame_tick(frame_tick)
    );

    typedef struct {
        logic [7:0] seg;
        logic [7:0] sel;
        logic [2:0] idx;
        logic       tick;
    } exp_t;

    typedef struct {
        logic       en;
        logic [7:0] l0;
        exp_t       e;
    } vec_t;

    exp_t  sb_q[$];
    vec_t  vecs[86];
    int    n_cmp = 0;
    int    n_err = 0;
    string tag;

    function automatic exp_t slot_exp(int idx, int cnt, logic [7:0] pat, logic tick);
        exp_t e;
        e.idx  = 3'(idx);
        e.tick = tick;
        if (DT && cnt < 1) begin
            e.seg = 8'hFF;
            e.sel = 8'hFF;
        end else begin
            e.seg = pat;
            e.sel = 8'hFF ^ (8'd1 << idx);
        end
        return e;
    endfunction

    function automatic exp_t blank_exp(int idx);
        exp_t e;
        e.seg  = 8'hFF;
        e.sel  = 8'hFF;
        e.idx  = 3'(idx);
        e.tick = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s %s: got %h expected %h", tag, name, act, req);
        end
    endtask

    task automatic cyc(input logic en, input exp_t e);
        exp_t got;
        enable = en;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        got = sb_q.pop_front();
        check("seg_out", seg_out, got.seg);
        check("digit_sel", digit_sel, got.sel);
        check("scan_index", {5'd0, scan_index}, {5'd0, got.idx});
        check("frame_tick", {7'd0, frame_tick}, {7'd0, got.tick});
    endtask

    task automatic set_inputs(input logic [7:0] base);
        l_in0 = base;        l_in1 = base + 8'd1; l_in2 = base + 8'd2; l_in3 = base + 8'd3;
        r_in0 = base + 8'd4; r_in1 = base + 8'd5; r_in2 = base + 8'd6; r_in3 = base + 8'd7;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t rst_e;
        rst_e = blank_exp(0);

        // Scan order, dead time and snapshot coherence: l_in0 changes to AA during slot 3.
        for (int j = 0; j < 86; j++) begin
            int         idx;
            logic [7:0] pat;
            idx = (j / 4) % 8;
            if (j == 0)        pat = 8'hFF;
            else if (idx == 0) pat = (j < 32) ? 8'h01 : 8'hAA;
            else               pat = 8'(idx + 1);
            vecs[j].en = 1'b1;
            vecs[j].l0 = (j >= 13) ? 8'hAA : 8'h01;
            vecs[j].e  = slot_exp(idx, j % 4, pat, (j % 32) == 31);
        end

        reset  = 1'b1;
        enable = 1'b1;
        set_inputs(8'h33);
        for (int i = 0; i < 3; i++) begin
            tag = $sformatf("reset[%0d]", i);
            cyc(1'b1, rst_e);
        end

        reset = 1'b0;
        set_inputs(8'h01);
        for (int j = 0; j < 86; j++) begin
            tag   = $sformatf("scan[%0d]", j);
            l_in0 = vecs[j].l0;
            cyc(vecs[j].en, vecs[j].e);
        end

        // Enable dropped at cnt=2 of slot 5, then a full slot 5 on re-enable.
        for (int i = 0; i < 10; i++) begin
            tag = $sformatf("disabled[%0d]", i);
            cyc(1'b0, blank_exp(5));
        end
        for (int c = 0; c < 4; c++) begin
            tag = $sformatf("reenable_slot5[%0d]", c);
            cyc(1'b1, slot_exp(5, c, 8'h06, 1'b0));
        end
        for (int c = 0; c < 2; c++) begin
            tag = $sformatf("slot6[%0d]", c);
            cyc(1'b1, slot_exp(6, c, 8'h07, 1'b0));
        end

        // Reset mid-slot 6 with changing inputs; the next frame uses inputs of the first enabled edge.
        reset = 1'b1;
        set_inputs(8'h5A);
        tag = "reset_mid";
        cyc(1'b1, rst_e);
        reset = 1'b0;
        set_inputs(8'h11);
        for (int j = 0; j < 36; j++) begin
            int idx;
            idx = (j / 4) % 8;
            tag = $sformatf("after_reset[%0d]", j);
            cyc(1'b1, slot_exp(idx, j % 4, (j == 0) ? 8'hFF : 8'(8'h11 + idx), j == 31));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
